packet_rr_arbiter: RTL

Packet-level round-robin arbiter that merges NUM_PORTS 64-bit packet streams into one output stream. Each input is the output side of a packet translator instance: valid/sop/eop/plen/data/half-word/bad with ready back-pressure. Once a port wins, it owns the output until its eop beat transfers, so packets are never interleaved. The output stage is registered to give a clean timing boundary toward the downstream consumer.

---
 rtl/packet_rr_arbiter.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/packet_rr_arbiter.sv
// packet_rr_arbiter
//   Merges NUM_PORTS packet streams into one registered output stream.
//   Ports are granted round-robin at packet granularity: the winner keeps
//   the output until its eop beat transfers, so packets never interleave.
//   Non-sop beats arriving on a port that does not own the output are
//   drained and discarded, and a sticky error flag records it.
//
//   Handshake: every stream uses valid/ready. A beat transfers in a cycle
//   where valid and ready are both high. Valid never depends on ready,
//   and ready may depend on valid.
//
// Ports
//   iclk, irst         clock, synchronous active-high reset
//   iport_en           per-port enable for winning a new grant
//   ivalid/isop/ieop   per-port beat valid / start / end of packet
//   iplen              per-port packet length (sampled with sop)
//   idata              per-port data, port i at [i*DATA_WIDTH +: DATA_WIDTH]
//   ihalf_word_valid   per-port half-word flag
//   ibad               per-port bad flag
//   iready             per-port ready
//   ovalid..obad       registered output beat
//   oport              source port of the output beat
//   oready             downstream ready
//   opkt_cnt           wrapping count of eop beats accepted downstream
//   oerr_orphan        sticky orphan-beat flag
//   ostate             arbiter state (0 = ARB, 1 = LOCKED), for debug
module packet_rr_arbiter #(
    parameter int NUM_PORTS  = 4,
    parameter int DATA_WIDTH = 64,
    parameter int PLEN_WIDTH = 14
) (
    input  logic                             iclk,
    input  logic                             irst,
    input  logic [NUM_PORTS-1:0]             iport_en,
    input  logic [NUM_PORTS-1:0]             ivalid,
    input  logic [NUM_PORTS-1:0]             isop,
    input  logic [NUM_PORTS-1:0]             ieop,
    input  logic [NUM_PORTS*PLEN_WIDTH-1:0]  iplen,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]  idata,
    input  logic [NUM_PORTS-1:0]             ihalf_word_valid,
    input  logic [NUM_PORTS-1:0]             ibad,
    output logic [NUM_PORTS-1:0]             iready,
    output logic                             ovalid,
    output logic                             osop,
    output logic                             oeop,
    output logic [PLEN_WIDTH-1:0]            oplen,
    output logic [DATA_WIDTH-1:0]            odata,
    output logic                             ohalf_word_valid,
    output logic                             obad,
    output logic [$clog2(NUM_PORTS)-1:0]     oport,
    input  logic                             oready,
    output logic [31:0]                      opkt_cnt,
    output logic                             oerr_orphan,
    output logic                             ostate
);
    localparam int PW = $clog2(NUM_PORTS);

    localparam logic ARB    = 1'b0;
    localparam logic LOCKED = 1'b1;

    logic                  state;
    logic [PW-1:0]         lock_port;
    logic [PW-1:0]         ptr;

    logic                  load_en;
    logic [NUM_PORTS-1:0]  cand;
    logic [NUM_PORTS-1:0]  orphan;
    logic                  found;
    logic [PW-1:0]         win;
    logic [PW-1:0]         sel;
    logic                  sel_active;
    logic [NUM_PORTS-1:0]  ready_c;
    logic                  xfer;
    logic                  orphan_drain;

    logic                  sel_sop;
    logic                  sel_eop;
    logic                  sel_valid;
    logic                  sel_ready;
    logic                  sel_hw;
    logic                  sel_bad;
    logic [PLEN_WIDTH-1:0] sel_plen;
    logic [DATA_WIDTH-1:0] sel_data;

    // The output register can take a new beat when empty or being drained.
    assign load_en = ~ovalid | oready;
    assign cand    = ivalid & isop & iport_en;
    assign orphan  = ivalid & ~isop;

    // Round-robin search starting just after the last winner, so the last
    // winner is considered last.
    always_comb begin
        int idx;
        found = 1'b0;
        win   = '0;
        idx   = 0;
        for (int k = 1; k <= NUM_PORTS; k++) begin
            idx = (int'(ptr) + k) % NUM_PORTS;
            if (!found && cand[idx]) begin
                found = 1'b1;
                win   = PW'(idx);
            end
        end
    end

    assign sel        = (state == LOCKED) ? lock_port : win;
    assign sel_active = (state == LOCKED) | found;

    // Orphans drain only in ARB and only when the output side is not
    // stalled, so no beat of any kind moves under back-pressure.
    always_comb begin
        ready_c = '0;
        if (!irst) begin
            if (state == ARB) begin
                if (load_en) ready_c = orphan;
                if (found) ready_c[win] = load_en;
            end else begin
                ready_c[lock_port] = load_en;
            end
        end
    end
    assign iready = ready_c;

    always_comb begin
        sel_sop   = 1'b0;
        sel_eop   = 1'b0;
        sel_valid = 1'b0;
        sel_ready = 1'b0;
        sel_hw    = 1'b0;
        sel_bad   = 1'b0;
        sel_plen  = '0;
        sel_data  = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (sel == PW'(i)) begin
                sel_sop   = isop[i];
                sel_eop   = ieop[i];
                sel_valid = ivalid[i];
                sel_ready = ready_c[i];
                sel_hw    = ihalf_word_valid[i];
                sel_bad   = ibad[i];
                sel_plen  = iplen[i*PLEN_WIDTH +: PLEN_WIDTH];
                sel_data  = idata[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign xfer         = sel_active & sel_valid & sel_ready;
    assign orphan_drain = (state == ARB) & (|(orphan & ready_c));
    assign ostate       = state;

    always_ff @(posedge iclk) begin
        if (irst) begin
            state            <= ARB;
            lock_port        <= '0;
            ptr              <= '0;
            ovalid           <= 1'b0;
            osop             <= 1'b0;
            oeop             <= 1'b0;
            oplen            <= '0;
            odata            <= '0;
            ohalf_word_valid <= 1'b0;
            obad             <= 1'b0;
            oport            <= '0;
            opkt_cnt         <= '0;
            oerr_orphan      <= 1'b0;
        end else begin
            if (load_en) begin
                ovalid <= xfer;
                if (xfer) begin
                    osop             <= sel_sop;
                    oeop             <= sel_eop;
                    oplen            <= sel_plen;
                    odata            <= sel_data;
                    ohalf_word_valid <= sel_hw;
                    obad             <= sel_bad;
                    oport            <= sel;
                end
            end

            if (ovalid && oready && oeop) opkt_cnt <= opkt_cnt + 32'd1;

            if (orphan_drain) oerr_orphan <= 1'b1;

            if (xfer) begin
                if (state == ARB) begin
                    ptr <= sel;
                    if (!sel_eop) begin
                        state     <= LOCKED;
                        lock_port <= sel;
                    end
                end else if (sel_eop) begin
                    state <= ARB;
                end
            end
        end
    end
endmodule
